// File: rtl/fir_filter_mc.sv
`default_nettype none
// ============================================================================
// Module   : fir_filter_mc
// Purpose  : Multi-channel time-multiplexed FIR filter with one shared MAC
//            and run-time loadable coefficients.
// Revision : 1.0
// ============================================================================
module fir_filter_mc #(
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 8,
    parameter int TAPS      = 8,
    parameter int CHANNELS  = 2,
    parameter int OUT_W     = 8,
    parameter int OUT_SHIFT = 0,
    parameter int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    parameter int K_W       = $clog2(TAPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [OUT_W-1:0]  out_data,
    input  logic              coef_we,
    input  logic [K_W-1:0]    coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    output logic              coef_err
);

    localparam int c_PROD_W = DATA_W + COEF_W;
    localparam int c_ACC_W  = DATA_W + COEF_W + K_W;
    localparam logic [CH_W:0] c_NCH  = (CH_W + 1)'(CHANNELS);
    localparam logic [K_W:0]  c_NTAP = (K_W + 1)'(TAPS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic                       r_alive;
    logic signed [DATA_W-1:0]   r_dly  [CHANNELS][TAPS];
    logic signed [COEF_W-1:0]   r_coef [TAPS];
    logic signed [c_ACC_W-1:0]  r_acc;
    logic [K_W-1:0]             r_k;
    logic [CH_W-1:0]            r_ch;
    logic signed [OUT_W-1:0]    r_out;
    logic                       r_coef_err;

    logic                       w_in_hs;
    logic                       w_ch_ok;
    logic                       w_accept;
    logic                       w_mac_last;
    logic                       w_coef_ok;
    logic signed [DATA_W-1:0]   w_x;
    logic signed [COEF_W-1:0]   w_c;
    logic signed [c_PROD_W-1:0] w_prod;
    logic signed [c_ACC_W-1:0]  w_sum;
    logic signed [c_ACC_W-1:0]  w_shift;
    logic signed [OUT_W-1:0]    w_sat;

    // r_alive holds in_ready low until the first edge after reset release
    assign in_ready   = (r_state == S_IDLE) & r_alive & ~rst;
    assign out_valid  = (r_state == S_OUT);
    assign out_ch     = r_ch;
    assign out_data   = r_out;
    assign coef_err   = r_coef_err;

    assign w_in_hs    = in_valid & in_ready;
    assign w_ch_ok    = ({1'b0, in_ch} < c_NCH);
    assign w_accept   = w_in_hs & w_ch_ok;
    assign w_mac_last = (r_k == K_W'(TAPS - 1));
    assign w_coef_ok  = ({1'b0, coef_addr} < c_NTAP) && (r_state == S_IDLE) && !w_in_hs;

    assign w_x     = r_dly[r_ch][r_k];
    assign w_c     = r_coef[r_k];
    assign w_prod  = c_PROD_W'(w_c) * c_PROD_W'(w_x);
    assign w_sum   = r_acc + c_ACC_W'(w_prod);
    assign w_shift = w_sum >>> OUT_SHIFT;

    generate
        if (OUT_W < c_ACC_W) begin : g_sat
            localparam logic signed [c_ACC_W-1:0] c_MAX =
                {{(c_ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
            localparam logic signed [c_ACC_W-1:0] c_MIN =
                {{(c_ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};
            always_comb begin
                w_sat = w_shift[OUT_W-1:0];
                if (w_shift > c_MAX) begin
                    w_sat = c_MAX[OUT_W-1:0];
                end else if (w_shift < c_MIN) begin
                    w_sat = c_MIN[OUT_W-1:0];
                end
            end
        end else begin : g_ext
            assign w_sat = OUT_W'(w_shift);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)   w_state_nxt = S_MAC;
            S_MAC:   if (w_mac_last) w_state_nxt = S_OUT;
            S_OUT:   if (out_ready)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alive    <= 1'b0;
            r_acc      <= '0;
            r_k        <= '0;
            r_ch       <= '0;
            r_out      <= '0;
            r_coef_err <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                for (int k = 0; k < TAPS; k++) begin
                    r_dly[c][k] <= '0;
                end
            end
            for (int k = 0; k < TAPS; k++) begin
                r_coef[k] <= '0;
            end
        end else begin
            r_alive    <= 1'b1;
            r_coef_err <= coef_we & ~w_coef_ok;
            if (coef_we && w_coef_ok) begin
                r_coef[coef_addr] <= coef_data;
            end

            // Out-of-range channels are handshaken but never reach this branch
            if (w_accept) begin
                r_ch  <= in_ch;
                r_k   <= '0;
                r_acc <= '0;
                for (int c = 0; c < CHANNELS; c++) begin
                    if (in_ch == CH_W'(c)) begin
                        r_dly[c][0] <= in_data;
                        for (int k = 1; k < TAPS; k++) begin
                            r_dly[c][k] <= r_dly[c][k-1];
                        end
                    end
                end
            end

            if (r_state == S_MAC) begin
                r_acc <= w_sum;
                r_k   <= r_k + K_W'(1);
                if (w_mac_last) begin
                    r_out <= w_sat;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_filter_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_filter_mc
// Purpose  : Self-checking bench for fir_filter_mc against an arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_fir_filter_mc;

    localparam int TAPS     = 4;
    localparam int CHANNELS = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [0:0] in_ch = '0;
    logic [7:0] in_data = '0;
    logic       out_ready = 1'b0;
    logic       coef_we = 1'b0;
    logic [1:0] coef_addr = '0;
    logic [7:0] coef_data = '0;

    logic       w_in_ready, w_out_valid, w_coef_err;
    logic [0:0] w_out_ch;
    logic [7:0] w_out_data;
    logic       w_in_ready_s8, w_out_valid_s8, w_coef_err_s8;
    logic [0:0] w_out_ch_s8;
    logic [7:0] w_out_data_s8;

    always #5 clk = ~clk;

    fir_filter_mc #(
        .DATA_W(8), .COEF_W(8), .TAPS(TAPS), .CHANNELS(CHANNELS), .OUT_W(8), .OUT_SHIFT(0)
    ) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(w_in_ready), .in_ch(in_ch), .in_data(in_data),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_ch(w_out_ch), .out_data(w_out_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(w_coef_err)
    );

    fir_filter_mc #(
        .DATA_W(8), .COEF_W(8), .TAPS(TAPS), .CHANNELS(CHANNELS), .OUT_W(8), .OUT_SHIFT(8)
    ) u_dut_s8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(w_in_ready_s8), .in_ch(in_ch), .in_data(in_data),
        .out_valid(w_out_valid_s8), .out_ready(out_ready), .out_ch(w_out_ch_s8), .out_data(w_out_data_s8),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(w_coef_err_s8)
    );

    int m_coef [TAPS];
    int m_hist [CHANNELS][TAPS];
    int exp0, exp8, exp_ch, hs_cyc;
    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input int got, input int expv);
        n_chk++;
        if (got == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, expv, $time);
    endtask

    function automatic int sat_sh(input int v, input int sh);
        int s;
        s = v >>> sh;
        if (s > 127) return 127;
        if (s < -128) return -128;
        return s;
    endfunction

    function automatic int fir_ref(input int ch);
        int a = 0;
        for (int k = 0; k < TAPS; k++) a += m_coef[k] * m_hist[ch][k];
        return a;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < TAPS; k++) begin
            m_coef[k] = 0;
            for (int c = 0; c < CHANNELS; c++) m_hist[c][k] = 0;
        end
    endtask

    // Called from an idle core only, so every write must be accepted
    task automatic write_coef(input int k, input int v);
        coef_we = 1'b1; coef_addr = 2'(k); coef_data = 8'(v);
        @(negedge clk);
        coef_we = 1'b0;
        chk("coef_err_idle", w_coef_err, 0);
        m_coef[k] = v;
    endtask

    task automatic load(input int a, input int b, input int c, input int d);
        write_coef(0, a); write_coef(1, b); write_coef(2, c); write_coef(3, d);
    endtask

    task automatic start_send(input int ch, input int d, input bit we_too);
        int n = 0;
        in_valid = 1'b1; in_ch = 1'(ch); in_data = 8'(d);
        if (we_too) begin
            coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'd77;
        end
        while (!w_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", w_in_ready, 1);
        @(negedge clk);
        hs_cyc = cyc;
        in_valid = 1'b0; coef_we = 1'b0;
        if (we_too) chk("coef_err_with_accept", w_coef_err, 1);
        for (int k = TAPS - 1; k > 0; k--) m_hist[ch][k] = m_hist[ch][k-1];
        m_hist[ch][0] = d;
        exp0 = sat_sh(fir_ref(ch), 0);
        exp8 = sat_sh(fir_ref(ch), 8);
        exp_ch = ch;
    endtask

    task automatic finish_recv(input int stall);
        int n = 0;
        while (!w_out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid", w_out_valid, 1);
        chk("latency_edges", cyc - hs_cyc, TAPS);
        chk("out_data", int'($signed(w_out_data)), exp0);
        chk("out_data_shift8", int'($signed(w_out_data_s8)), exp8);
        chk("out_ch", int'(w_out_ch), exp_ch);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_valid", w_out_valid, 1);
            chk("stall_data", int'($signed(w_out_data)), exp0);
            chk("stall_ch", int'(w_out_ch), exp_ch);
            chk("stall_in_ready", w_in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_out_valid", w_out_valid, 0);
        chk("post_in_ready", w_in_ready, 1);
    endtask

    task automatic xfer(input int ch, input int d, input int stall);
        start_send(ch, d, 1'b0);
        finish_recv(stall);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        model_reset();
        #12;
        chk("rst_in_ready", w_in_ready, 0);
        chk("rst_out_valid", w_out_valid, 0);
        chk("rst_out_data", int'(w_out_data), 0);
        chk("rst_out_ch", int'(w_out_ch), 0);
        chk("rst_coef_err", w_coef_err, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("in_ready_before_edge", w_in_ready, 0);
        @(negedge clk);
        chk("in_ready_after_edge", w_in_ready, 1);

        // Impulse response on ch0
        load(1, 2, 3, 4);
        xfer(0, 1, 0);
        for (int i = 0; i < 4; i++) xfer(0, 0, 0);

        // Interleaved impulses, channels must not interact
        xfer(0, 10, 0);
        xfer(1, -5, 1);
        for (int i = 0; i < 3; i++) begin
            xfer(0, 0, 0);
            xfer(1, 0, 0);
        end

        // Saturation both directions, plus the OUT_SHIFT=8 instance
        load(127, 127, 127, 127);
        for (int i = 0; i < 4; i++) xfer(0, 127, 0);
        for (int i = 0; i < 4; i++) xfer(0, -128, 0);

        // Long backpressure
        xfer(1, 33, 20);

        // Coefficient writes while busy are dropped
        load(1, 2, 3, 4);
        start_send(0, 1, 1'b1);
        coef_we = 1'b1; coef_addr = 2'd1; coef_data = 8'd99;
        @(negedge clk);
        coef_we = 1'b0;
        chk("coef_err_mac", w_coef_err, 1);
        @(negedge clk);
        chk("coef_err_pulse_end", w_coef_err, 0);
        finish_recv(0);
        for (int i = 0; i < 3; i++) xfer(0, 0, 0);

        // Reset during MAC aborts the computation
        start_send(1, 50, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", w_in_ready, 0);
        chk("midrst_out_valid", w_out_valid, 0);
        chk("midrst_out_data", int'(w_out_data), 0);
        chk("midrst_out_ch", int'(w_out_ch), 0);
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_hold_in_ready", w_in_ready, 0);
        end
        rst = 1'b0;
        #1;
        chk("midrst_release_in_ready", w_in_ready, 0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (w_out_valid) seen++;
        end
        chk("midrst_no_output", seen, 0);
        xfer(0, 1, 0);

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) == 0)
                write_coef(int'($urandom_range(0, TAPS - 1)), int'($urandom_range(0, 255)) - 128);
            xfer(int'($urandom_range(0, CHANNELS - 1)), int'($urandom_range(0, 255)) - 128,
                 int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
